fft_seq_ctrl: RTL and testbench
===============================

FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 Parameter LOG2N, default 4, log2 of FFT point count N = 2**LOG2N; legal range 2..10.
REQ-002 Parameter STG_W, default 4, width of the stage output; SHALL be >= clog2(LOG2N).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  run request; sampled only in IDLE.
REQ-006 abort  in  1  cancel the run in progress.
REQ-007 mem_gnt  in  1  SRAM grant for the current mem_req; read data valid in the same cycle.
REQ-008 bb_valid  in  1  butterfly datapath result ready.
REQ-009 mem_req  out  1  SRAM access request.
REQ-010 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-011 mem_addr  out  LOG2N  SRAM sample address.
REQ-012 tw_addr  out  LOG2N-1  twiddle ROM index k.
REQ-013 ld_a, ld_b, ld_w  out  1 each  datapath operand load strobes for A, B and W.
REQ-014 bb_start  out  1  one-cycle butterfly launch pulse.
REQ-015 wr_sel  out  1  write-back select: 0 = A', 1 = B'.
REQ-016 stage  out  STG_W  current stage index s.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle completion pulse.

Function
REQ-019 FSM states: IDLE, RD_A, RD_B, RD_W, BB_WAIT, WR_A, WR_B, NEXT, DONE.
REQ-020 Loop counters: stage s runs 0..LOG2N-1; butterfly b runs 0..N/2-1 within each stage.
REQ-021 Address arithmetic, all unsigned:
  - half = 1<<s; pos = b & (half-1); grp = b>>s
  - addrA = (grp<<(s+1)) | pos; addrB = addrA + half
  - k = pos << (LOG2N-1-s)
REQ-022 IDLE -> RD_A when start=1; s and b SHALL be cleared on this transition.
REQ-023 RD_A: mem_req=1, mem_we=0, mem_addr=addrA; on mem_gnt, ld_a=1 and the FSM moves to RD_B; without mem_gnt it holds and keeps the address stable.
REQ-024 RD_B: same as RD_A but with addrB and ld_b; on mem_gnt it moves to RD_W.
REQ-025 RD_W: tw_addr=k and ld_w=1 for one cycle, with no mem_req; it moves to BB_WAIT.
REQ-026 BB_WAIT: bb_start=1 in the first cycle only; bb_valid is ignored in that cycle and sampled from the second cycle on; bb_valid=1 moves the FSM to WR_A.
REQ-027 WR_A: mem_req=1, mem_we=1, mem_addr=addrA, wr_sel=0; on mem_gnt it moves to WR_B.
REQ-028 WR_B: same as WR_A with addrB and wr_sel=1; on mem_gnt it moves to NEXT.
REQ-029 NEXT:
  - b<N/2-1: b++ and go to RD_A
  - otherwise if s<LOG2N-1: b=0, s++ and go to RD_A
  - otherwise go to DONE
REQ-030 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-031 stage SHALL equal s zero-extended to STG_W bits at all times.
REQ-032 All outputs not listed for the current state SHALL be 0, except stage.
REQ-033 start while busy=1 SHALL be ignored and not queued; start in the DONE cycle SHALL also be ignored.
REQ-034 abort=1 in any non-IDLE state SHALL move the FSM to IDLE next cycle:
  - no done pulse; s and b are cleared
  - abort wins over a simultaneous mem_gnt or bb_valid
  - abort in IDLE has no effect; abort and start together in IDLE keep the FSM in IDLE.
REQ-035 mem_addr and mem_we SHALL remain constant while mem_req=1 and mem_gnt=0.
REQ-036 Minimum cost is 8 cycles per butterfly; a full run is (LOG2N*N/2)*8 cycles plus DONE.

Reset
REQ-037 rst=1 SHALL force IDLE and clear s and b on the next edge, from any state including mid-access.
REQ-038 After reset every output SHALL be 0: mem_req, mem_we, mem_addr, tw_addr, ld_a, ld_b, ld_w, bb_start, wr_sel, stage, busy, done.
REQ-039 rst SHALL have priority over abort and start.

Verification
REQ-040 LOG2N=2, mem_gnt=1, bb_valid=1, start pulse at cycle 0:
  - (addrA, addrB, k) sequence (0,1,0), (2,3,0), (0,2,0), (1,3,1)
  - stage 0,0,1,1
  - done=1 in cycle 33 only.
REQ-041 LOG2N=4, gnt tied high: 32 butterflies, done in cycle 257; stage 3 addresses run (0,8,0)..(7,15,7).
REQ-042 gnt withheld 3 cycles in RD_B and WR_A: mem_addr held stable, ld_b pulses once, total run length increases by 6.
REQ-043 bb_valid high in the bb_start cycle and low for 4 more cycles: FSM leaves BB_WAIT only when bb_valid is sampled high on the 6th cycle.
REQ-044 abort during WR_B of butterfly 2: IDLE next cycle, no done; a new start restarts with addresses (0,1,0).
REQ-045 rst asserted in BB_WAIT, and start asserted during busy: all outputs 0 after rst; the start during busy does not cause a second run.

Source files
------------

// File: rtl/fft_seq_ctrl_if.sv
// Handshake bundle between the FFT sequencer and its SRAM, twiddle ROM and butterfly datapath.
interface fft_seq_ctrl_if #(
  parameter int LOG2N = 4,
  parameter int STG_W = 4
);
  logic             start;
  logic             abort;
  logic             mem_gnt;
  logic             bb_valid;
  logic             mem_req;
  logic             mem_we;
  logic [LOG2N-1:0] mem_addr;
  logic [LOG2N-2:0] tw_addr;
  logic             ld_a;
  logic             ld_b;
  logic             ld_w;
  logic             bb_start;
  logic             wr_sel;
  logic [STG_W-1:0] stage;
  logic             busy;
  logic             done;

  modport master (
    input  start, abort, mem_gnt, bb_valid,
    output mem_req, mem_we, mem_addr, tw_addr, ld_a, ld_b, ld_w,
           bb_start, wr_sel, stage, busy, done
  );

  modport slave (
    output start, abort, mem_gnt, bb_valid,
    input  mem_req, mem_we, mem_addr, tw_addr, ld_a, ld_b, ld_w,
           bb_start, wr_sel, stage, busy, done
  );
endinterface

// File: rtl/fft_seq_ctrl.sv
// FFT sequencing controller: walks every radix-2 butterfly stage by stage, issuing
// SRAM reads/writes, twiddle fetches and datapath strobes.
module fft_seq_ctrl #(
  parameter int LOG2N = 4,
  parameter int STG_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  fft_seq_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, RD_A, RD_B, RD_W, BB_WAIT, WR_A, WR_B, NEXT, DONE
  } state_t;

  localparam int               B_W    = LOG2N - 1;
  localparam logic [B_W-1:0]   B_ONE  = B_W'(1);
  localparam logic [B_W-1:0]   B_ALL  = '1;
  localparam logic [STG_W-1:0] S_ONE  = STG_W'(1);
  localparam logic [STG_W-1:0] S_LAST = STG_W'(LOG2N - 1);
  localparam logic [LOG2N-1:0] A_ONE  = LOG2N'(1);

  state_t           state, state_nxt;
  logic [STG_W-1:0] s;
  logic [B_W-1:0]   b;
  logic             bb_armed;
  logic [B_W-1:0]   pos, grp, k;
  logic [LOG2N-1:0] half, addr_a, addr_b;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state != IDLE && bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start && !bus.abort) state_nxt = RD_A;
        RD_A:    if (bus.mem_gnt) state_nxt = RD_B;
        RD_B:    if (bus.mem_gnt) state_nxt = RD_W;
        RD_W:    state_nxt = BB_WAIT;
        BB_WAIT: if (bb_armed && bus.bb_valid) state_nxt = WR_A;
        WR_A:    if (bus.mem_gnt) state_nxt = WR_B;
        WR_B:    if (bus.mem_gnt) state_nxt = NEXT;
        NEXT:    state_nxt = (b != B_ALL || s != S_LAST) ? RD_A : DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Counters return to zero whenever the FSM heads back to IDLE (done, abort or reset).
  always_ff @(posedge clk) begin
    if (rst || state_nxt == IDLE) begin
      s <= '0;
      b <= '0;
    end else if (state == NEXT) begin
      if (b != B_ALL) begin
        b <= b + B_ONE;
      end else if (s != S_LAST) begin
        b <= '0;
        s <= s + S_ONE;
      end
    end
  end

  // bb_valid is only trusted from the second BB_WAIT cycle, after the launch pulse.
  always_ff @(posedge clk) begin
    if (rst) bb_armed <= 1'b0;
    else     bb_armed <= (state == BB_WAIT);
  end

  always_comb begin
    pos    = b & ~(B_ALL << s);
    grp    = b >> s;
    half   = A_ONE << s;
    addr_a = ({1'b0, grp} << (s + S_ONE)) | {1'b0, pos};
    addr_b = addr_a + half;
    k      = pos << (S_LAST - s);
  end

  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.tw_addr  = '0;
    bus.ld_a     = 1'b0;
    bus.ld_b     = 1'b0;
    bus.ld_w     = 1'b0;
    bus.bb_start = 1'b0;
    bus.wr_sel   = 1'b0;
    bus.stage    = s;
    bus.busy     = (state != IDLE);
    bus.done     = 1'b0;
    case (state)
      RD_A: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr_a;
        bus.ld_a     = bus.mem_gnt;
      end
      RD_B: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr_b;
        bus.ld_b     = bus.mem_gnt;
      end
      RD_W: begin
        bus.tw_addr = k;
        bus.ld_w    = 1'b1;
      end
      BB_WAIT: bus.bb_start = !bb_armed;
      WR_A: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = addr_a;
      end
      WR_B: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = addr_b;
        bus.wr_sel   = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl: a 4-point instance for timing/abort/reset
// scenarios and a 16-point instance for the full address walk.
module tb_fft_seq_ctrl;

  logic clk = 1'b0;
  logic rstS, rstL;
  int   nChecks = 0;
  int   nFails  = 0;

  fft_seq_ctrl_if #(.LOG2N(2), .STG_W(4)) sif ();
  fft_seq_ctrl_if #(.LOG2N(4), .STG_W(4)) lif ();

  fft_seq_ctrl #(.LOG2N(2), .STG_W(4)) dutS (.clk(clk), .rst(rstS), .bus(sif));
  fft_seq_ctrl #(.LOG2N(4), .STG_W(4)) dutL (.clk(clk), .rst(rstL), .bus(lif));

  always #5 clk = ~clk;

  int outsTr[64], addrTr[64], reqTr[64], weTr[64], ldbTr[64], bbsTr[64], busyTr[64];
  int aLog[$], bLog[$], kLog[$], sLog[$];
  int doneCyc, doneCnt;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic gn,
                               input logic bv, input logic rs);
    @(posedge clk);
    #1;
    sif.start    = st;
    sif.abort    = ab;
    sif.mem_gnt  = gn;
    sif.bb_valid = bv;
    rstS         = rs;
    #1;
  endtask

  function automatic int smallOuts();
    return int'({sif.mem_req, sif.mem_we, sif.mem_addr, sif.tw_addr, sif.ld_a, sif.ld_b,
                 sif.ld_w, sif.bb_start, sif.wr_sel, sif.stage, sif.busy, sif.done});
  endfunction

  function automatic int largeOuts();
    return int'({lif.mem_req, lif.mem_we, lif.mem_addr, lif.tw_addr, lif.ld_a, lif.ld_b,
                 lif.ld_w, lif.bb_start, lif.wr_sel, lif.stage, lif.busy, lif.done});
  endfunction

  // Cycle c of a run is the c-th cycle after the one where stimulus bit 0 is applied.
  task automatic runSmall(input logic [63:0] stMask, input logic [63:0] gnLow,
                          input logic [63:0] bvLow, input logic [63:0] abMask,
                          input logic [63:0] rsMask, input int ncyc);
    aLog.delete(); bLog.delete(); kLog.delete(); sLog.delete();
    doneCyc = -1;
    doneCnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      applyStimulus(stMask[c], abMask[c], ~gnLow[c], ~bvLow[c], rsMask[c]);
      outsTr[c] = smallOuts();
      addrTr[c] = int'(sif.mem_addr);
      reqTr[c]  = int'(sif.mem_req);
      weTr[c]   = int'(sif.mem_we);
      ldbTr[c]  = int'(sif.ld_b);
      bbsTr[c]  = int'(sif.bb_start);
      busyTr[c] = int'(sif.busy);
      if (sif.ld_a) aLog.push_back(int'(sif.mem_addr));
      if (sif.ld_b) bLog.push_back(int'(sif.mem_addr));
      if (sif.ld_w) begin
        kLog.push_back(int'(sif.tw_addr));
        sLog.push_back(int'(sif.stage));
      end
      if (sif.done) begin
        if (doneCyc < 0) doneCyc = c;
        doneCnt++;
      end
    end
  endtask

  task automatic runLarge(input int ncyc);
    aLog.delete(); bLog.delete(); kLog.delete(); sLog.delete();
    doneCyc = -1;
    doneCnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      rstL         = 1'b0;
      lif.start    = (c == 0);
      lif.abort    = 1'b0;
      lif.mem_gnt  = 1'b1;
      lif.bb_valid = 1'b1;
      #1;
      if (lif.ld_a) aLog.push_back(int'(lif.mem_addr));
      if (lif.ld_b) bLog.push_back(int'(lif.mem_addr));
      if (lif.ld_w) begin
        kLog.push_back(int'(lif.tw_addr));
        sLog.push_back(int'(lif.stage));
      end
      if (lif.done) begin
        if (doneCyc < 0) doneCyc = c;
        doneCnt++;
      end
    end
  endtask

  initial begin
    int expA[4] = '{0, 2, 0, 1};
    int expB[4] = '{1, 3, 2, 3};
    int expK[4] = '{0, 0, 0, 1};
    int expS[4] = '{0, 0, 1, 1};
    int cnt;

    rstS = 1'b1; rstL = 1'b1;
    sif.start = 1'b0; sif.abort = 1'b0; sif.mem_gnt = 1'b0; sif.bb_valid = 1'b0;
    lif.start = 1'b0; lif.abort = 1'b0; lif.mem_gnt = 1'b0; lif.bb_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_outs_small", smallOuts(), 0);
    checkOutput("reset_outs_large", largeOuts(), 0);

    // Plain run, with extra starts during busy (cycle 10) and in the DONE cycle (33).
    runSmall((64'd1 << 0) | (64'd1 << 10) | (64'd1 << 33), '0, '0, '0, '0, 45);
    checkOutput("n4_butterflies", aLog.size(), 4);
    if (aLog.size() == 4 && bLog.size() == 4 && kLog.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("n4_addrA[%0d]", i), aLog[i], expA[i]);
        checkOutput($sformatf("n4_addrB[%0d]", i), bLog[i], expB[i]);
        checkOutput($sformatf("n4_k[%0d]", i), kLog[i], expK[i]);
        checkOutput($sformatf("n4_stage[%0d]", i), sLog[i], expS[i]);
      end
    end
    checkOutput("n4_done_cycle", doneCyc, 33);
    checkOutput("n4_done_count", doneCnt, 1);
    checkOutput("n4_rd_a_outs", outsTr[1], 16'h8402);
    checkOutput("n4_rd_w_outs", outsTr[3], 16'h0102);
    checkOutput("n4_bb_first_outs", outsTr[4], 16'h0082);
    checkOutput("n4_bb_second_outs", outsTr[5], 16'h0002);
    checkOutput("n4_wr_b_outs", outsTr[7], 16'hD042);
    checkOutput("n4_rd_w_last_outs", outsTr[27], 16'h0906);
    checkOutput("n4_idle_after_done", outsTr[34], 0);
    checkOutput("n4_no_second_run", busyTr[40], 0);

    // Grant withheld for three cycles in RD_B and in WR_A of the first butterfly.
    runSmall(64'd1, (64'd7 << 2) | (64'd7 << 9), '0, '0, '0, 45);
    cnt = 0;
    for (int c = 2; c <= 5; c++) begin
      checkOutput($sformatf("gnt_rdb_addr[%0d]", c), addrTr[c], 1);
      checkOutput($sformatf("gnt_rdb_we[%0d]", c), weTr[c], 0);
      cnt += ldbTr[c];
    end
    checkOutput("gnt_ldb_once", cnt, 1);
    checkOutput("gnt_ldb_at_grant", ldbTr[5], 1);
    for (int c = 9; c <= 12; c++) begin
      checkOutput($sformatf("gnt_wra_addr[%0d]", c), addrTr[c], 0);
      checkOutput($sformatf("gnt_wra_we[%0d]", c), weTr[c], 1);
    end
    checkOutput("gnt_done_cycle", doneCyc, 39);

    // bb_valid high in the launch cycle, low four cycles, high again on the sixth.
    runSmall(64'd1, '0, 64'hF << 5, '0, '0, 45);
    checkOutput("bbv_launch", bbsTr[4], 1);
    checkOutput("bbv_still_waiting", outsTr[9], 16'h0002);
    checkOutput("bbv_wr_a_req", reqTr[10], 1);
    checkOutput("bbv_wr_a_we", weTr[10], 1);
    checkOutput("bbv_done_cycle", doneCyc, 37);

    // Abort in WR_B of the third butterfly, then abort+start together while idle.
    runSmall((64'd1 << 0) | (64'd1 << 30), '0, '0, (64'd1 << 23) | (64'd1 << 30), '0, 35);
    checkOutput("abort_wr_b_outs", outsTr[23], 16'hE046);
    checkOutput("abort_idle_outs", outsTr[24], 0);
    checkOutput("abort_no_done", doneCnt, 0);
    checkOutput("abort_start_idle", busyTr[31], 0);
    runSmall(64'd1, '0, '0, '0, '0, 40);
    checkOutput("restart_count", aLog.size(), 4);
    if (aLog.size() > 0 && bLog.size() > 0 && kLog.size() > 0) begin
      checkOutput("restart_addrA", aLog[0], 0);
      checkOutput("restart_addrB", bLog[0], 1);
      checkOutput("restart_k", kLog[0], 0);
      checkOutput("restart_stage", sLog[0], 0);
    end
    checkOutput("restart_done_cycle", doneCyc, 33);

    // Reset in BB_WAIT, start during busy, then reset together with start.
    runSmall((64'd1 << 0) | (64'd1 << 2) | (64'd1 << 5), '0, '0, '0,
             (64'd1 << 4) | (64'd1 << 5), 12);
    checkOutput("rst_bb_outs", outsTr[4], 16'h0082);
    checkOutput("rst_after_outs", outsTr[5], 0);
    checkOutput("rst_over_start", outsTr[6], 0);
    checkOutput("rst_no_rerun", busyTr[11], 0);
    checkOutput("rst_no_done", doneCnt, 0);

    // 16-point run with grant and bb_valid tied high.
    runLarge(270);
    checkOutput("n16_butterflies", kLog.size(), 32);
    checkOutput("n16_done_cycle", doneCyc, 257);
    checkOutput("n16_done_count", doneCnt, 1);
    if (aLog.size() == 32 && bLog.size() == 32 && kLog.size() == 32) begin
      checkOutput("n16_b0_addrA", aLog[0], 0);
      checkOutput("n16_b0_addrB", bLog[0], 1);
      checkOutput("n16_b1_addrA", aLog[1], 2);
      checkOutput("n16_b1_addrB", bLog[1], 3);
      checkOutput("n16_s1b1_addrA", aLog[9], 1);
      checkOutput("n16_s1b1_addrB", bLog[9], 3);
      checkOutput("n16_s1b1_k", kLog[9], 4);
      checkOutput("n16_s1b1_stage", sLog[9], 1);
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("n16_s3_addrA[%0d]", i), aLog[24 + i], i);
        checkOutput($sformatf("n16_s3_addrB[%0d]", i), bLog[24 + i], i + 8);
        checkOutput($sformatf("n16_s3_k[%0d]", i), kLog[24 + i], i);
        checkOutput($sformatf("n16_s3_stage[%0d]", i), sLog[24 + i], 3);
      end
    end
    checkOutput("n16_idle_outs", largeOuts(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
